// File: rtl/maze_pkg.sv
// Shared constants, state encoding and the side-clamping rule for the maze generator.
package maze_pkg;

   localparam int          MIN_N        = 5;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      CARVE,
      OPEN,
      DONE
   } state_t;

   // Clamp the requested side into [MIN_N, max_n], then round down to odd.
   function automatic int clamp_side(input int n, input int max_n);
      int a;
      a = (n < MIN_N) ? MIN_N : ((n > max_n) ? max_n : n);
      if (a % 2 == 0) a = a - 1;
      return a;
   endfunction

endpackage

// File: rtl/maze_lfsr.sv
// Right-shifting Galois LFSR; a zero seed is replaced by DEFAULT_SEED so it never locks up.
module maze_lfsr
   import maze_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_sys,
   input  logic         load,
   input  logic         enable,
   input  logic [W-1:0] seed,
   output logic [W-1:0] out
);

   localparam logic [W-1:0] TAPS      = W'(LFSR_TAPS);
   localparam logic [W-1:0] SEED_ZERO = W'(DEFAULT_SEED);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst_sys) begin
         out <= SEED_ZERO;
      end else if (load) begin
         out <= (seed == '0) ? SEED_ZERO : seed;
      end else if (enable) begin
         out <= (out >> 1) ^ (out[0] ? TAPS : '0);
      end
   end

endmodule

// File: rtl/maze_gen_param.sv
// Binary-tree maze generator: fills a MAX_N x MAX_N wall map, carves one cell per
// cycle in row-major order, then opens the entrance and exit.
module maze_gen_param
   import maze_pkg::*;
#(
   parameter int MAX_N  = 19,
   parameter int NUM_W  = 5,
   parameter int SEED_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_sys,
   input  logic                   rst_map,
   input  logic [NUM_W-1:0]       num,
   input  logic [SEED_W-1:0]      seed,
   output logic [MAX_N*MAX_N-1:0] map,
   output logic [NUM_W-1:0]       actual_num,
   output logic                   busy,
   output logic                   done
);

   localparam int               TILES = MAX_N * MAX_N;
   localparam int               IDX_W = $clog2(TILES);
   localparam logic [NUM_W-1:0] ZERO  = NUM_W'(0);
   localparam logic [NUM_W-1:0] ONE   = NUM_W'(1);
   localparam logic [NUM_W-1:0] TWO   = NUM_W'(2);

   state_t             state;
   state_t             state_next;
   logic               rst_map_q;
   logic               start;
   logic [NUM_W-1:0]   row;
   logic [NUM_W-1:0]   col;
   logic [NUM_W-1:0]   last_rc;
   logic               last_col;
   logic               last_cell;
   logic [SEED_W-1:0]  lfsr;
   logic               carve_left;
   logic               wall_en;
   logic [NUM_W-1:0]   wall_r;
   logic [NUM_W-1:0]   wall_c;

   function automatic logic [IDX_W-1:0] tile_idx(input logic [NUM_W-1:0] r,
                                                 input logic [NUM_W-1:0] c);
      return IDX_W'(int'(r) * MAX_N + int'(c));
   endfunction

   assign start      = rst_map & ~rst_map_q;
   assign last_rc    = actual_num - TWO;
   assign last_col   = (col == last_rc);
   assign last_cell  = last_col && (row == last_rc);
   assign carve_left = |(lfsr & SEED_W'(1));

   maze_lfsr #(.W(SEED_W)) u_lfsr (
      .clk    (clk),
      .rst_sys(rst_sys),
      .load   (start),
      .enable ((state == CARVE) && !start),
      .seed   (seed),
      .out    (lfsr)
   );

   always_ff @(posedge clk) begin
      if (rst_sys) begin
         rst_map_q <= 1'b0;
         state     <= IDLE;
      end else begin
         rst_map_q <= rst_map;
         state     <= state_next;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE:  state_next = IDLE;
         FILL:  begin busy = 1'b1; state_next = CARVE; end
         CARVE: begin busy = 1'b1; if (last_cell) state_next = OPEN; end
         OPEN:  begin busy = 1'b1; state_next = DONE; end
         DONE:  begin done = 1'b1; state_next = IDLE; end
         default: state_next = IDLE;
      endcase
      if (start) state_next = FILL;
   end

   // Wall removed alongside the current cell: west on row 1, north on column 1, else LFSR choice.
   always_comb begin
      wall_en = 1'b0;
      wall_r  = row;
      wall_c  = col;
      if (!(row == ONE && col == ONE)) begin
         wall_en = 1'b1;
         if (row == ONE)       wall_c = col - ONE;
         else if (col == ONE)  wall_r = row - ONE;
         else if (carve_left)  wall_c = col - ONE;
         else                  wall_r = row - ONE;
      end
   end

   // NOTE: map is plain flops rather than a RAM, so it can and does take a reset value.
   always_ff @(posedge clk) begin
      if (rst_sys) begin
         map        <= '1;
         actual_num <= '0;
         row        <= ONE;
         col        <= ONE;
      end else if (start) begin
         actual_num <= NUM_W'(clamp_side(int'(num), MAX_N));
         row        <= ONE;
         col        <= ONE;
      end else begin
         case (state)
            FILL: begin
               map <= '1;
               row <= ONE;
               col <= ONE;
            end
            CARVE: begin
               map[tile_idx(row, col)] <= 1'b0;
               if (wall_en) map[tile_idx(wall_r, wall_c)] <= 1'b0;
               if (last_col) begin
                  col <= ONE;
                  row <= row + TWO;
               end else begin
                  col <= col + TWO;
               end
            end
            OPEN: begin
               map[tile_idx(ONE, ZERO)]                <= 1'b0;
               map[tile_idx(last_rc, actual_num - ONE)] <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/maze_gen_param.md
MAZE_GEN_PARAM -- requirements
Module: maze_gen_param

Interface
REQ-001 Parameter MAX_N, default 19, SHALL be the maximum maze side in tiles; odd, at least 5.
REQ-002 Parameter NUM_W, default 5, SHALL be the width of num/actual_num; 2**NUM_W > MAX_N.
REQ-003 Parameter SEED_W, default 16, SHALL be the seed/LFSR width.
REQ-004 clk  input  1  SHALL be the single clock; all logic on rising edge.
REQ-005 rst_sys  input  1  SHALL be the synchronous, active-high system reset.
REQ-006 rst_map  input  1  SHALL be the regenerate request; its rising edge starts a generation.
REQ-007 num  input  NUM_W  SHALL be the requested maze side.
REQ-008 seed  input  SEED_W  SHALL be the LFSR seed, latched at start.
REQ-009 map  output  MAX_N*MAX_N  SHALL be the tile map; bit row*MAX_N+col, 1 = wall, 0 = open.
REQ-010 actual_num  output  NUM_W  SHALL be the side actually generated.
REQ-011 busy  output  1  SHALL be high while generation runs.
REQ-012 done  output  1  SHALL pulse high for one cycle when map is complete.

Function
REQ-013 Start: rst_map sampled 1 with previous sample 0 SHALL start a generation; a level held high starts only once.
REQ-014 At start, actual_num SHALL be clamp(num, 5, MAX_N), rounded down to odd (num=20 -> 19, num=3 -> 5, num=8 -> 7).
REQ-015 States: IDLE, FILL, CARVE, OPEN, DONE; the start edge moves IDLE -> FILL next cycle.
REQ-016 FILL SHALL last 1 cycle and set every map bit to 1.
REQ-017 CARVE SHALL visit cells (r,c), r,c odd in 1..actual_num-2, row-major, one cell per cycle; k=(actual_num-1)/2 gives k*k cycles.
REQ-018 Each visited cell SHALL be cleared.
REQ-019 Cell (1,1): no further carve. Row 1: clear (r,c-1). Column 1: clear (r-1,c). Otherwise LFSR bit 0 selects: 0 clears (r-1,c), 1 clears (r,c-1).
REQ-020 LFSR: Galois, taps 0xB400 for SEED_W=16, loaded from seed at start (seed 0 -> 16'hACE1); advances once per CARVE cycle, after bit 0 is used.
REQ-021 OPEN SHALL last 1 cycle and clear entrance (1,0) and exit (actual_num-2, actual_num-1).
REQ-022 DONE SHALL last 1 cycle with done=1, busy=0, then return to IDLE.
REQ-023 busy SHALL be 1 in FILL, CARVE and OPEN; total busy time is k*k+2 cycles.
REQ-024 Tiles with row or column >= actual_num SHALL remain 1.
REQ-025 A start edge during FILL/CARVE/OPEN/DONE SHALL abort and restart at FILL with newly latched num and seed.
REQ-026 map and actual_num SHALL hold their values in IDLE until the next start.
REQ-027 Same seed and num SHALL produce a bit-identical map.

Reset
REQ-028 rst_sys SHALL set: state IDLE, map all ones, actual_num 0, busy 0, done 0, LFSR 16'hACE1, rst_map edge history 0.
REQ-029 rst_sys SHALL dominate a simultaneous rst_map edge and SHALL abort any in-progress generation.

Structure
REQ-030 Package maze_pkg SHALL hold MIN_N=5, DEFAULT_SEED=16'hACE1, LFSR_TAPS=16'hB400 and the state enum.
REQ-031 Sub-module maze_lfsr (load, enable, seed, out) SHALL implement the LFSR.

Verification
REQ-032 num=19, seed=1, one rst_map pulse -> actual_num=19; busy for 83 cycles; one done pulse; map[19]=0 and map[17*19+18]=0; 163 zero bits in total.
REQ-033 num=3 -> actual_num=5; busy for 6 cycles; tiles (1,1),(1,3),(3,1),(3,3) are 0; row/col >= 5 all 1.
REQ-034 num=20 with MAX_N=19 -> actual_num=19; num=8 -> actual_num=7 with 9 cells carved; map outside 7x7 all 1.
REQ-035 Two runs with seed=16'h1234, num=15 -> identical map; seed=16'h4321 -> differing map; rst_map held high 50 cycles -> exactly one done.
REQ-036 rst_sys asserted mid-CARVE -> next cycle map all ones, busy=0, done never pulses; rst_map edge mid-CARVE -> restart, done comes k*k+2 cycles after restart.
